// File: rtl/alu.sv
// 4x4 matrix ALU: bus-loaded operands A/B, opcode-triggered operation, registered result read.
// Elements are 16-bit, packed row-major with element (0,0) in the top bits.
module alu #(
   parameter int unsigned DW = 16,
   parameter int unsigned N  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [N*N*DW-1:0]   out,
   input  logic [N*N*DW-1:0]   in,
   input  logic                enable,
   input  logic [7:0]          opcode,
   input  logic                readwrite,
   output logic                status
);

   localparam int unsigned W = N * N * DW;

   typedef enum logic {SEL_A, SEL_B} ptr_t;
   typedef enum logic [2:0] {
      OP_ADD   = 3'b001,
      OP_SUB   = 3'b010,
      OP_MULT  = 3'b011,
      OP_SCALE = 3'b100,
      OP_TRANS = 3'b101
   } op_t;

   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [W-1:0]  result;
   logic [W-1:0]  calc;
   logic          calc_ok;
   logic [DW-1:0] scale;
   logic [DW-1:0] acc;
   ptr_t          ptr;

   function automatic logic [DW-1:0] elem(input logic [W-1:0] m, input int unsigned r,
                                          input int unsigned c);
      return m[W-1-DW*(N*r+c) -: DW];
   endfunction

   // Undefined opcodes leave calc equal to the current result, so only status changes.
   always_comb begin
      calc    = result;
      calc_ok = 1'b1;
      scale   = DW'(opcode[6:3]);
      acc     = '0;
      case (opcode[2:0])
         OP_ADD: begin
            for (int unsigned r = 0; r < N; r++)
               for (int unsigned c = 0; c < N; c++)
                  calc[W-1-DW*(N*r+c) -: DW] = elem(a, r, c) + elem(b, r, c);
         end
         OP_SUB: begin
            for (int unsigned r = 0; r < N; r++)
               for (int unsigned c = 0; c < N; c++)
                  calc[W-1-DW*(N*r+c) -: DW] = elem(a, r, c) - elem(b, r, c);
         end
         OP_MULT: begin
            for (int unsigned r = 0; r < N; r++)
               for (int unsigned c = 0; c < N; c++) begin
                  acc = '0;
                  for (int unsigned k = 0; k < N; k++)
                     acc = acc + elem(a, r, k) * elem(b, k, c);
                  calc[W-1-DW*(N*r+c) -: DW] = acc;
               end
         end
         OP_SCALE: begin
            for (int unsigned r = 0; r < N; r++)
               for (int unsigned c = 0; c < N; c++)
                  calc[W-1-DW*(N*r+c) -: DW] = elem(a, r, c) * scale;
         end
         OP_TRANS: begin
            for (int unsigned r = 0; r < N; r++)
               for (int unsigned c = 0; c < N; c++)
                  calc[W-1-DW*(N*r+c) -: DW] = elem(a, c, r);
         end
         default: calc_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a      <= '0;
         b      <= '0;
         result <= '0;
         out    <= '0;
         ptr    <= SEL_A;
         status <= 1'b0;
      end else if (enable && !readwrite) begin
         if (ptr == SEL_A) a <= in;
         else              b <= in;
         ptr    <= (ptr == SEL_A) ? SEL_B : SEL_A;
         status <= 1'b0;
      end else if (enable) begin
         out <= result;
      end else if (opcode[7]) begin
         result <= calc;
         status <= calc_ok;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors plus random traffic against an array-based model.
module tb_alu;

   logic         clk;
   logic         rst_n;
   logic [255:0] out;
   logic [255:0] in;
   logic         enable;
   logic [7:0]   opcode;
   logic         readwrite;
   logic         status;

   int total;
   int bad;

   logic [15:0]  ma   [4][4];
   logic [15:0]  mb   [4][4];
   logic [15:0]  mres [4][4];
   logic [255:0] mout;
   logic         mstat;
   logic         mptr;

   alu #(.DW(16), .N(4)) dut (
      .clk(clk), .rst_n(rst_n), .out(out), .in(in), .enable(enable),
      .opcode(opcode), .readwrite(readwrite), .status(status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] pack_res();
      logic [255:0] v;
      v = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            v[255-16*(4*r+c) -: 16] = mres[r][c];
      return v;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            ma[r][c] = '0; mb[r][c] = '0; mres[r][c] = '0;
         end
      mout = '0; mstat = 1'b0; mptr = 1'b0;
   endtask

   task automatic model_exec(input logic [7:0] op);
      int unsigned s;
      case (op[2:0])
         3'd1: for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) mres[r][c] = ma[r][c] + mb[r][c];
         3'd2: for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) mres[r][c] = ma[r][c] - mb[r][c];
         3'd3: for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
                  s = 0;
                  for (int k = 0; k < 4; k++) s += ma[r][k] * mb[k][c];
                  mres[r][c] = s[15:0];
               end
         3'd4: for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) mres[r][c] = ma[r][c] * op[6:3];
         3'd5: for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) mres[r][c] = ma[c][r];
         default: ;
      endcase
      mstat = (op[2:0] >= 3'd1 && op[2:0] <= 3'd5);
   endtask

   // Drives one edge's worth of inputs, predicts the model, then checks out/status after the edge.
   task automatic step(input string tag, input logic en, input logic rw, input logic [7:0] op,
                       input logic [255:0] d);
      enable = en; readwrite = rw; opcode = op; in = d;
      if (en && !rw) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               if (!mptr) ma[r][c] = d[255-16*(4*r+c) -: 16];
               else       mb[r][c] = d[255-16*(4*r+c) -: 16];
         mptr = ~mptr;
         mstat = 1'b0;
      end else if (en) begin
         mout = pack_res();
      end else if (op[7]) begin
         model_exec(op);
      end
      @(posedge clk);
      #1;
      chk({tag, ".out"}, out, mout);
      chk({tag, ".status"}, {255'b0, status}, {255'b0, mstat});
      enable = 1'b0; opcode = 8'h00;
   endtask

   localparam logic [255:0] OPA = 256'h0004_000c_0004_0022_0007_0006_000b_0009_0009_0002_0008_000d_0002_000f_0010_0003;
   localparam logic [255:0] OPB = 256'h0017_002d_001f_0016_0007_0006_0004_0001_0012_000c_000d_000c_000d_0005_0007_0013;

   initial begin
      logic [255:0] prev;
      logic [255:0] rnd;
      int unsigned  pick;
      total = 0; bad = 0;
      rst_n = 1'b0; enable = 1'b0; readwrite = 1'b0; opcode = 8'h00; in = '0;
      model_reset();
      #12;
      chk("reset.out", out, '0);
      chk("reset.status", {255'b0, status}, '0);
      rst_n = 1'b1;

      step("read_before_exec", 1'b1, 1'b1, 8'h00, '0);
      chk("read_before_exec.zero", out, '0);

      step("wr_a", 1'b1, 1'b0, 8'h81, OPA);
      step("wr_b", 1'b1, 1'b0, 8'h00, OPB);
      step("add", 1'b0, 1'b0, 8'h81, '0);
      step("add_rd", 1'b1, 1'b1, 8'h00, '0);
      chk("add.const", out, 256'h001b_0039_0023_0038_000e_000c_000f_000a_001b_000e_0015_0019_000f_0014_0017_0016);
      chk("add.status", {255'b0, status}, 256'd1);

      step("sub", 1'b0, 1'b0, 8'h82, '0);
      step("sub_rd", 1'b1, 1'b1, 8'h00, '0);
      chk("sub.const", out, 256'hffed_ffdf_ffe5_000c_0000_0000_0007_0008_fff7_fff6_fffb_0001_fff5_000a_0009_fff0);

      step("mult", 1'b0, 1'b0, 8'h83, '0);
      step("mult_rd", 1'b1, 1'b1, 8'h00, '0);
      chk("mult.e00", {240'b0, out[255:240]}, 256'h02b2);

      step("scale", 1'b0, 1'b0, 8'hBC, '0);
      step("scale_rd", 1'b1, 1'b1, 8'h00, '0);
      chk("scale.row0", {192'b0, out[255:192]}, 256'h001c_0054_001c_00ee);

      step("trans", 1'b0, 1'b0, 8'h85, '0);
      step("trans_rd", 1'b1, 1'b1, 8'h00, '0);
      chk("trans.row0", {192'b0, out[255:192]}, 256'h0004_0007_0009_0002);
      prev = out;

      step("undef", 1'b0, 1'b0, 8'h80, '0);
      chk("undef.status", {255'b0, status}, '0);
      step("undef_rd", 1'b1, 1'b1, 8'h00, '0);
      chk("undef.prev", out, prev);

      step("exec_again", 1'b0, 1'b0, 8'h81, '0);
      rnd = {8{$urandom()}};
      step("wr3", 1'b1, 1'b0, 8'h00, rnd);
      chk("wr3.status", {255'b0, status}, '0);
      step("wr3_trans", 1'b0, 1'b0, 8'h85, '0);
      step("wr3_rd", 1'b1, 1'b1, 8'h00, '0);

      // asynchronous reset asserted and released between edges
      rst_n = 1'b0;
      #2;
      model_reset();
      chk("midrst.out", out, '0);
      chk("midrst.status", {255'b0, status}, '0);
      #2;
      rst_n = 1'b1;
      rnd = {8{$urandom()}};
      step("post_rst_wr", 1'b1, 1'b0, 8'h00, rnd);
      step("post_rst_add", 1'b0, 1'b0, 8'h81, '0);
      step("post_rst_rd", 1'b1, 1'b1, 8'h00, '0);
      chk("post_rst.a_only", out, rnd);

      for (int i = 0; i < 400; i++) begin
         pick = $urandom_range(0, 9);
         for (int j = 0; j < 8; j++) rnd[32*j +: 32] = $urandom();
         if (pick < 3)       step("rnd_wr", 1'b1, 1'b0, 8'($urandom()), rnd);
         else if (pick < 5)  step("rnd_rd", 1'b1, 1'b1, 8'($urandom()), rnd);
         else if (pick < 9)  step("rnd_ex", 1'b0, 1'b0, {1'b1, 7'($urandom())}, rnd);
         else                step("rnd_idle", 1'b0, $urandom_range(0, 1) == 1, {1'b0, 7'($urandom())}, rnd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
